// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of a combinational 4-bit ALU: issues registered operands,
// captures the result and flags, and keeps an accumulator, sticky overflow and op count.
module alu_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  input  logic             cmd_acc,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_c,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_c,
  output logic             res_zero,
  output logic             res_ovf,
  output logic [WIDTH-1:0] acc,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_cnt
);
  // Both handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer keeps valid and its payload stable until that edge.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   cmd_fire;
  logic   acc_write;
  logic   ovf_op;

  // In DONE a new command may enter only on the edge that also drains the result.
  assign cmd_ready = (state == IDLE) || ((state == DONE) && res_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign acc_write = (alu_op != OP_SLT) && (alu_op != OP_EQ);
  assign ovf_op    = (alu_op == OP_ADD) || (alu_op == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_op     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      res_valid  <= 1'b0;
      res_s      <= '0;
      res_c      <= 1'b0;
      res_zero   <= 1'b0;
      res_ovf    <= 1'b0;
      acc        <= '0;
      sticky_ovf <= 1'b0;
      op_cnt     <= '0;
    end else begin
      // A capture later in this block overrides the clear when both land together.
      if (clr_sticky) sticky_ovf <= 1'b0;

      if (cmd_fire) begin
        alu_op <= cmd_op;
        alu_x  <= cmd_acc ? acc : cmd_x;
        alu_y  <= cmd_y;
      end

      case (state)
        IDLE: begin
          if (cmd_fire) state <= EXEC;
        end
        EXEC: begin
          res_s     <= alu_s;
          res_c     <= alu_c;
          res_zero  <= alu_zero;
          res_ovf   <= alu_ovf;
          res_valid <= 1'b1;
          op_cnt    <= op_cnt + CNT_ONE;
          if (acc_write) acc <= alu_s;
          if (ovf_op && alu_ovf) sticky_ovf <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= cmd_valid ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
